// File: rtl/rv3n_func_op_sched_pkg.sv
// Shared constants, request/grant types and the round-robin pick used by the
// rv3n_func_op scheduler and its result queues.
package rv3n_func_op_sched_pkg;

    localparam int XLEN            = 32;
    localparam int SCHED_NREQ      = 2;
    localparam int SCHED_TAG_W_DEF = 4;
    localparam int PARA_W          = 8;
    localparam int IMM_W           = 13;

    typedef enum logic {
        SRC_REQ0 = 1'b0,
        SRC_REQ1 = 1'b1
    } src_e;

    typedef struct packed {
        logic [PARA_W-1:0] para;
        logic [IMM_W-1:0]  imm;
        logic [XLEN-1:0]   pc;
        logic [XLEN-1:0]   op0;
        logic [XLEN-1:0]   op1;
    } fu_req_t;

    typedef struct packed {
        logic g1;
        logic g0;
    } grant_t;

    // Under contention the requester that did not win last time gets the unit.
    function automatic grant_t rr_arbitrate(input logic elig0, input logic elig1,
                                            input src_e rr_last);
        grant_t g;
        g.g0 = elig0 & (~elig1 | (rr_last == SRC_REQ1));
        g.g1 = elig1 & (~elig0 | (rr_last == SRC_REQ0));
        return g;
    endfunction

endpackage

// File: rtl/rv3n_func_op_resq.sv
// DEPTH-entry ring FIFO holding {result, tag} for one requester; pops of an
// empty queue are ignored and push+pop at full is legal.
module rv3n_func_op_resq #(
    parameter int DEPTH = 3,
    parameter int W     = 36
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         push_i,
    input  logic [W-1:0]                 push_data_i,
    input  logic                         pop_i,
    output logic [W-1:0]                 head_o,
    output logic [$clog2(DEPTH+1)-1:0]   cnt_o,
    output logic                         valid_o
);

    localparam int CNT_W = $clog2(DEPTH + 1);
    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [PTR_W-1:0] PTR_LAST = PTR_W'(DEPTH - 1);
    localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(DEPTH);

    logic [W-1:0]     mem_q [DEPTH];
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             do_push;
    logic             do_pop;

    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        return (p == PTR_LAST) ? '0 : p + 1'b1;
    endfunction

    assign do_pop  = pop_i & (cnt_q != '0);
    assign do_push = push_i & ((cnt_q != CNT_FULL) | do_pop);

    // NOTE: every variable gets its hold value first so no path can infer a latch.
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        cnt_d    = cnt_q;
        if (do_push) wr_ptr_d = ptr_inc(wr_ptr_q);
        if (do_pop)  rd_ptr_d = ptr_inc(rd_ptr_q);
        case ({do_push, do_pop})
            2'b10:   cnt_d = cnt_q + 1'b1;
            2'b01:   cnt_d = cnt_q - 1'b1;
            default: cnt_d = cnt_q;
        endcase
    end

    // NOTE: state is updated with non-blocking assignments so all flops see pre-edge values.
    always_ff @(posedge clk) begin
        if (!rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            cnt_q    <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            cnt_q    <= cnt_d;
        end
    end

    // NOTE: storage is not reset; cnt_q gates whether any entry is meaningful.
    always_ff @(posedge clk) begin
        if (do_push) mem_q[wr_ptr_q] <= push_data_i;
    end

    assign head_o  = mem_q[rd_ptr_q];
    assign cnt_o   = cnt_q;
    assign valid_o = (cnt_q != '0);

endmodule

// File: rtl/rv3n_func_op_sched.sv
// Round-robin, credit-gated scheduler sharing one 1-cycle rv3n_func_op unit
// between two requesters, with a per-requester result queue.
module rv3n_func_op_sched
    import rv3n_func_op_sched_pkg::*;
#(
    parameter int TAG_W     = SCHED_TAG_W_DEF,
    parameter int RES_DEPTH = 3
) (
    input  logic              clk,
    input  logic              rst,

    input  logic              req0_valid,
    output logic              req0_ready,
    input  logic [7:0]        req0_para,
    input  logic [12:0]       req0_imm,
    input  logic [XLEN-1:0]   req0_pc,
    input  logic [XLEN-1:0]   req0_op0,
    input  logic [XLEN-1:0]   req0_op1,
    input  logic [TAG_W-1:0]  req0_tag,

    input  logic              req1_valid,
    output logic              req1_ready,
    input  logic [7:0]        req1_para,
    input  logic [12:0]       req1_imm,
    input  logic [XLEN-1:0]   req1_pc,
    input  logic [XLEN-1:0]   req1_op0,
    input  logic [XLEN-1:0]   req1_op1,
    input  logic [TAG_W-1:0]  req1_tag,

    output logic              resp0_valid,
    input  logic              resp0_ready,
    output logic [XLEN-1:0]   resp0_data,
    output logic [TAG_W-1:0]  resp0_tag,

    output logic              resp1_valid,
    input  logic              resp1_ready,
    output logic [XLEN-1:0]   resp1_data,
    output logic [TAG_W-1:0]  resp1_tag,

    output logic              func_op_req_valid,
    output logic [7:0]        func_op_req_para,
    output logic [12:0]       func_op_req_imm,
    output logic [XLEN-1:0]   func_op_req_pc,
    output logic [XLEN-1:0]   func_op_req_operand0,
    output logic [XLEN-1:0]   func_op_req_operand1,
    input  logic              func_op_ack_valid,
    input  logic [XLEN-1:0]   func_op_ack_data,
    input  logic              func_op_ack_busy,

    output logic              sched_err
);

    localparam int CNT_W = $clog2(RES_DEPTH + 1);
    localparam int ENT_W = XLEN + TAG_W;

    fu_req_t                 req_fields [SCHED_NREQ];
    fu_req_t                 win_fields;
    logic [SCHED_NREQ-1:0]   req_valid_w;
    logic [SCHED_NREQ-1:0]   credit;
    logic [SCHED_NREQ-1:0]   elig;
    logic [SCHED_NREQ-1:0]   push;
    logic [SCHED_NREQ-1:0]   pop;
    logic [SCHED_NREQ-1:0]   q_valid;
    logic [CNT_W-1:0]        q_cnt  [SCHED_NREQ];
    logic [ENT_W-1:0]        q_head [SCHED_NREQ];

    grant_t                  gnt;
    logic                    issue;
    src_e                    winner;

    logic                    infl_valid_q, infl_valid_d;
    src_e                    infl_src_q,   infl_src_d;
    logic [TAG_W-1:0]        infl_tag_q,   infl_tag_d;
    src_e                    rr_last_q,    rr_last_d;
    logic                    err_q,        err_d;

    assign req_fields[0] = '{para: req0_para, imm: req0_imm, pc: req0_pc,
                             op0: req0_op0, op1: req0_op1};
    assign req_fields[1] = '{para: req1_para, imm: req1_imm, pc: req1_pc,
                             op0: req1_op0, op1: req1_op1};
    assign req_valid_w   = {req1_valid, req0_valid};

    // Credit counts the in-flight op for its destination; a same-cycle pop
    // deliberately does not return credit, keeping pop off the grant path.
    always_comb begin
        credit = '0;
        for (int n = 0; n < SCHED_NREQ; n++) begin
            credit[n] = (int'(q_cnt[n]) +
                         int'(infl_valid_q && (int'(infl_src_q) == n))) < RES_DEPTH;
        end
        elig = req_valid_w & credit & {SCHED_NREQ{~func_op_ack_busy & rst}};
    end

    assign gnt        = rr_arbitrate(elig[0], elig[1], rr_last_q);
    assign issue      = gnt.g0 | gnt.g1;
    assign winner     = gnt.g1 ? SRC_REQ1 : SRC_REQ0;
    assign win_fields = gnt.g1 ? req_fields[1] : req_fields[0];

    always_comb begin
        infl_valid_d = issue;
        infl_src_d   = infl_src_q;
        infl_tag_d   = infl_tag_q;
        rr_last_d    = rr_last_q;
        err_d        = err_q;
        if (issue) begin
            infl_src_d = winner;
            infl_tag_d = gnt.g1 ? req1_tag : req0_tag;
            rr_last_d  = winner;
        end
        if (func_op_ack_valid && !infl_valid_q) err_d = 1'b1;
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            infl_valid_q <= 1'b0;
            infl_src_q   <= SRC_REQ0;
            infl_tag_q   <= '0;
            rr_last_q    <= SRC_REQ1;
            err_q        <= 1'b0;
        end else begin
            infl_valid_q <= infl_valid_d;
            infl_src_q   <= infl_src_d;
            infl_tag_q   <= infl_tag_d;
            rr_last_q    <= rr_last_d;
            err_q        <= err_d;
        end
    end

    always_comb begin
        push = '0;
        for (int n = 0; n < SCHED_NREQ; n++) begin
            push[n] = func_op_ack_valid & infl_valid_q & (int'(infl_src_q) == n);
        end
    end

    assign pop = {resp1_ready, resp0_ready} & q_valid;

    for (genvar n = 0; n < SCHED_NREQ; n++) begin : g_resq
        rv3n_func_op_resq #(
            .DEPTH (RES_DEPTH),
            .W     (ENT_W)
        ) u_resq (
            .clk         (clk),
            .rst         (rst),
            .push_i      (push[n]),
            .push_data_i ({func_op_ack_data, infl_tag_q}),
            .pop_i       (pop[n]),
            .head_o      (q_head[n]),
            .cnt_o       (q_cnt[n]),
            .valid_o     (q_valid[n])
        );
    end

    assign req0_ready           = gnt.g0;
    assign req1_ready           = gnt.g1;

    assign func_op_req_valid    = issue;
    assign func_op_req_para     = win_fields.para;
    assign func_op_req_imm      = win_fields.imm;
    assign func_op_req_pc       = win_fields.pc;
    assign func_op_req_operand0 = win_fields.op0;
    assign func_op_req_operand1 = win_fields.op1;

    // Result-side outputs are forced low while reset is held.
    assign resp0_valid = rst & q_valid[0];
    assign resp0_data  = rst ? q_head[0][ENT_W-1:TAG_W] : '0;
    assign resp0_tag   = rst ? q_head[0][TAG_W-1:0]     : '0;
    assign resp1_valid = rst & q_valid[1];
    assign resp1_data  = rst ? q_head[1][ENT_W-1:TAG_W] : '0;
    assign resp1_tag   = rst ? q_head[1][TAG_W-1:0]     : '0;

    assign sched_err   = rst & err_q;

endmodule

// File: tb/tb_rv3n_func_op_sched.sv
// Scoreboard bench: stimulus drives both requesters, a monitor predicts grants
// from credit/round-robin rules and checks every result popped from the queues.
module tb_rv3n_func_op_sched;
    import rv3n_func_op_sched_pkg::*;

    localparam int TAG_W     = 4;
    localparam int RES_DEPTH = 3;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic              rst;
    logic              req0_valid, req1_valid;
    logic              req0_ready, req1_ready;
    logic [7:0]        req0_para, req1_para;
    logic [12:0]       req0_imm, req1_imm;
    logic [XLEN-1:0]   req0_pc, req1_pc, req0_op0, req1_op0, req0_op1, req1_op1;
    logic [TAG_W-1:0]  req0_tag, req1_tag;
    logic              resp0_valid, resp1_valid, resp0_ready, resp1_ready;
    logic [XLEN-1:0]   resp0_data, resp1_data;
    logic [TAG_W-1:0]  resp0_tag, resp1_tag;
    logic              func_op_req_valid;
    logic [7:0]        func_op_req_para;
    logic [12:0]       func_op_req_imm;
    logic [XLEN-1:0]   func_op_req_pc, func_op_req_operand0, func_op_req_operand1;
    logic              func_op_ack_valid;
    logic [XLEN-1:0]   func_op_ack_data;
    logic              func_op_ack_busy;
    logic              sched_err;

    logic              unit_v = 1'b0;
    logic [XLEN-1:0]   unit_d = '0;
    logic              stray_v;

    int errors = 0;
    int checks = 0;

    rv3n_func_op_sched #(.TAG_W(TAG_W), .RES_DEPTH(RES_DEPTH)) dut (
        .clk(clk), .rst(rst),
        .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_para(req0_para),
        .req0_imm(req0_imm), .req0_pc(req0_pc), .req0_op0(req0_op0),
        .req0_op1(req0_op1), .req0_tag(req0_tag),
        .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_para(req1_para),
        .req1_imm(req1_imm), .req1_pc(req1_pc), .req1_op0(req1_op0),
        .req1_op1(req1_op1), .req1_tag(req1_tag),
        .resp0_valid(resp0_valid), .resp0_ready(resp0_ready),
        .resp0_data(resp0_data), .resp0_tag(resp0_tag),
        .resp1_valid(resp1_valid), .resp1_ready(resp1_ready),
        .resp1_data(resp1_data), .resp1_tag(resp1_tag),
        .func_op_req_valid(func_op_req_valid), .func_op_req_para(func_op_req_para),
        .func_op_req_imm(func_op_req_imm), .func_op_req_pc(func_op_req_pc),
        .func_op_req_operand0(func_op_req_operand0),
        .func_op_req_operand1(func_op_req_operand1),
        .func_op_ack_valid(func_op_ack_valid), .func_op_ack_data(func_op_ack_data),
        .func_op_ack_busy(func_op_ack_busy), .sched_err(sched_err)
    );

    function automatic logic [XLEN-1:0] alu(input logic [7:0] para,
                                            input logic [XLEN-1:0] a,
                                            input logic [XLEN-1:0] b);
        case (para)
            8'h00:   return a + b;
            8'h08:   return a - b;
            8'h03:   return a ^ b;
            default: return '0;
        endcase
    endfunction

    // Behavioural 1-cycle unit; stray_v injects an ack with nothing in flight.
    always @(posedge clk) begin
        unit_v <= func_op_req_valid;
        unit_d <= alu(func_op_req_para, func_op_req_operand0, func_op_req_operand1);
    end
    assign func_op_ack_valid = unit_v | stray_v;
    assign func_op_ack_data  = unit_d;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- scoreboard / monitor ----------------
    typedef struct {
        logic [XLEN-1:0]  data;
        logic [TAG_W-1:0] tag;
        int               vis;
    } exp_t;

    exp_t q0[$];
    exp_t q1[$];
    exp_t popped;
    int   pend0 = 0, pend1 = 0, m_rr = 1, cyc = 0;
    bit   m_err = 0, m_issued_last = 0;
    bit   e0, e1, g0, g1, ev0, ev1;

    initial begin
        forever begin
            @(negedge clk);
            cyc++;
            ev0 = (q0.size() > 0) && (q0[0].vis <= cyc);
            ev1 = (q1.size() > 0) && (q1[0].vis <= cyc);
            if (rst) begin
                e0 = req0_valid && (pend0 < RES_DEPTH) && !func_op_ack_busy;
                e1 = req1_valid && (pend1 < RES_DEPTH) && !func_op_ack_busy;
                g0 = e0 && (!e1 || m_rr == 1);
                g1 = e1 && (!e0 || m_rr == 0);
                check("req0_ready", req0_ready, g0);
                check("req1_ready", req1_ready, g1);
                check("func_op_req_valid", func_op_req_valid, g0 || g1);
                check("req_para_imm", {func_op_req_para, func_op_req_imm},
                      g1 ? {req1_para, req1_imm} : {req0_para, req0_imm});
                check("req_pc", func_op_req_pc, g1 ? req1_pc : req0_pc);
                check("req_operands", {func_op_req_operand0, func_op_req_operand1},
                      g1 ? {req1_op0, req1_op1} : {req0_op0, req0_op1});
                check("resp0_valid", resp0_valid, ev0);
                if (ev0) begin
                    check("resp0_data", resp0_data, q0[0].data);
                    check("resp0_tag", resp0_tag, q0[0].tag);
                end
                check("resp1_valid", resp1_valid, ev1);
                if (ev1) begin
                    check("resp1_data", resp1_data, q1[0].data);
                    check("resp1_tag", resp1_tag, q1[0].tag);
                end
                check("sched_err", sched_err, m_err);
            end else begin
                check("rst_ctrl_outputs", {req0_ready, req1_ready, func_op_req_valid,
                                           resp0_valid, resp1_valid, sched_err}, '0);
                check("rst_resp_data", {resp0_data, resp1_data}, '0);
                check("rst_resp_tag", {resp0_tag, resp1_tag}, '0);
            end

            if (!rst) begin
                q0.delete();
                q1.delete();
                pend0 = 0;
                pend1 = 0;
                m_rr = 1;
                m_err = 0;
                m_issued_last = 0;
            end else begin
                if (func_op_ack_valid && !m_issued_last) m_err = 1;
                if (ev0 && resp0_ready) begin popped = q0.pop_front(); pend0--; end
                if (ev1 && resp1_ready) begin popped = q1.pop_front(); pend1--; end
                if (req0_valid && req0_ready) begin
                    q0.push_back('{alu(req0_para, req0_op0, req0_op1), req0_tag, cyc + 2});
                    pend0++;
                    m_rr = 0;
                end
                if (req1_valid && req1_ready) begin
                    q1.push_back('{alu(req1_para, req1_op0, req1_op1), req1_tag, cyc + 2});
                    pend1++;
                    m_rr = 1;
                end
                m_issued_last = func_op_req_valid;
                check("no_overflow", (pend0 <= RES_DEPTH) && (pend1 <= RES_DEPTH), 1'b1);
            end
        end
    end

    // ---------------- stimulus ----------------
    logic [7:0] op_tab [3] = '{8'h00, 8'h08, 8'h03};

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic rand_op(output logic [7:0] para, output logic [12:0] imm,
                           output logic [XLEN-1:0] pc, output logic [XLEN-1:0] a,
                           output logic [XLEN-1:0] b, output logic [TAG_W-1:0] tag);
        para = op_tab[$urandom_range(2, 0)];
        imm  = 13'($urandom);
        pc   = XLEN'($urandom);
        a    = XLEN'($urandom);
        b    = XLEN'($urandom);
        tag  = TAG_W'($urandom);
    endtask

    initial begin
        rst = 1'b0;
        stray_v = 1'b0;
        func_op_ack_busy = 1'b0;
        resp0_ready = 1'b1;
        resp1_ready = 1'b1;
        req0_valid = 1'b0; req1_valid = 1'b0;
        req0_para = '0; req0_imm = '0; req0_pc = '0; req0_op0 = '0; req0_op1 = '0; req0_tag = '0;
        req1_para = '0; req1_imm = '0; req1_pc = '0; req1_op0 = '0; req1_op1 = '0; req1_tag = '0;
        repeat (3) step();
        rst = 1'b1;

        // Single add on requester 0: 5 + 7 with tag 3.
        req0_valid = 1'b1; req0_para = 8'h00; req0_op0 = 5; req0_op1 = 7; req0_tag = 4'd3;
        step();
        req0_valid = 1'b0;
        repeat (4) step();

        // Contention: sub 10-3 on requester 0, xor 6^3 on requester 1.
        req0_para = 8'h08; req0_op0 = 10; req0_op1 = 3;
        req1_para = 8'h03; req1_op0 = 6;  req1_op1 = 3;
        req0_valid = 1'b1; req1_valid = 1'b1;
        for (int i = 0; i < 8; i++) begin
            req0_tag = TAG_W'(i);
            req1_tag = TAG_W'(i + 8);
            step();
        end
        req0_valid = 1'b0; req1_valid = 1'b0;
        repeat (4) step();

        // Backpressure on queue 0 while requester 1 keeps flowing.
        resp0_ready = 1'b0;
        req0_valid = 1'b1; req1_valid = 1'b1;
        for (int i = 0; i < 10; i++) begin
            req0_tag = TAG_W'(i);
            req0_op0 = XLEN'(i * 3);
            step();
        end
        resp0_ready = 1'b1;
        repeat (6) step();
        req0_valid = 1'b0; req1_valid = 1'b0;
        repeat (4) step();

        // Unit busy for 4 cycles with both requesters pending.
        func_op_ack_busy = 1'b1;
        req0_valid = 1'b1; req1_valid = 1'b1;
        repeat (4) step();
        func_op_ack_busy = 1'b0;
        repeat (3) step();
        req0_valid = 1'b0; req1_valid = 1'b0;
        repeat (4) step();

        // Reset with an op in flight, stray ack right after release, then a fresh op.
        req0_valid = 1'b1; req0_para = 8'h00; req0_op0 = 100; req0_op1 = 1; req0_tag = 4'd9;
        step();
        req0_valid = 1'b0;
        rst = 1'b0;
        repeat (2) step();
        rst = 1'b1;
        stray_v = 1'b1;
        step();
        stray_v = 1'b0;
        req0_valid = 1'b1; req0_para = 8'h03; req0_op0 = 32'hF0F0; req0_op1 = 32'h0FF0; req0_tag = 4'd5;
        step();
        req0_valid = 1'b0;
        repeat (4) step();

        // Randomized traffic with random backpressure and occasional busy.
        for (int i = 0; i < 600; i++) begin
            rand_op(req0_para, req0_imm, req0_pc, req0_op0, req0_op1, req0_tag);
            rand_op(req1_para, req1_imm, req1_pc, req1_op0, req1_op1, req1_tag);
            req0_valid       = ($urandom_range(3, 0) != 0);
            req1_valid       = ($urandom_range(3, 0) != 0);
            resp0_ready      = ($urandom_range(3, 0) != 0);
            resp1_ready      = ($urandom_range(2, 0) != 0);
            func_op_ack_busy = ($urandom_range(7, 0) == 0);
            step();
        end

        req0_valid = 1'b0; req1_valid = 1'b0;
        resp0_ready = 1'b1; resp1_ready = 1'b1;
        func_op_ack_busy = 1'b0;
        repeat (8) step();

        @(negedge clk);
        #1;
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
